// File: rtl/gray_ptr_ctrl.sv
// One side of a dual-clock FIFO pointer path: local binary/Gray pointer, remote Gray
// synchroniser and registered full/empty, almost and level outputs (MODE 0 = write, 1 = read).
module gray_ptr_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned MODE          = 0,
  parameter int unsigned ALMOST_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic                  ok,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   bin,
  output logic [ADDR_WIDTH:0]   gray,
  input  logic [ADDR_WIDTH:0]   remote_gray,
  output logic                  blocked,
  output logic                  almost,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int unsigned P     = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [P-1:0] DEPTH_P  = P'(DEPTH);
  localparam logic [P-1:0] AF_LIMIT = P'(DEPTH - ALMOST_THRESH);
  localparam logic [P-1:0] AE_LIMIT = P'(ALMOST_THRESH);

  // Write side comes out of reset empty (not full); read side comes out empty (blocked).
  localparam logic BLOCKED_RST = (MODE != 0);
  localparam logic ALMOST_RST  = (MODE != 0) ? 1'b1 : (ALMOST_THRESH >= DEPTH);

  logic [P-1:0]                  bin_q, gray_q, level_q;
  logic                          blocked_q, almost_q;
  logic [SYNC_STAGES-1:0][P-1:0] sync_q;

  logic         acc;
  logic [P-1:0] nbin, ngray, rbin, nlevel;
  logic         blocked_d, almost_d;

  assign acc   = inc & ~blocked_q;
  assign nbin  = bin_q + P'(acc);
  assign ngray = nbin ^ (nbin >> 1);

  always_comb begin
    rbin = '0;
    for (int i = 0; i < P; i++) begin
      rbin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
  end

  // Level uses the next local pointer so a local accept shows up in the flags immediately.
  always_comb begin
    nlevel    = '0;
    blocked_d = 1'b0;
    almost_d  = 1'b0;
    if (MODE == 0) begin
      nlevel    = nbin - rbin;
      blocked_d = (nlevel == DEPTH_P);
      almost_d  = (nlevel >= AF_LIMIT);
    end else begin
      nlevel    = rbin - nbin;
      blocked_d = (nlevel == '0);
      almost_d  = (nlevel <= AE_LIMIT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      gray_q    <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      blocked_q <= BLOCKED_RST;
      almost_q  <= ALMOST_RST;
    end else begin
      bin_q     <= nbin;
      gray_q    <= ngray;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], remote_gray};
      level_q   <= nlevel;
      blocked_q <= blocked_d;
      almost_q  <= almost_d;
    end
  end

  assign ok      = acc;
  assign addr    = bin_q[ADDR_WIDTH-1:0];
  assign bin     = bin_q;
  assign gray    = gray_q;
  assign blocked = blocked_q;
  assign almost  = almost_q;
  assign level   = level_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Directed bench for gray_ptr_ctrl: a write-side and a read-side instance, ADDR_WIDTH=4.
module tb_gray_ptr_ctrl;

  logic       clk, rst;
  logic       inc_w, ok_w, blocked_w, almost_w;
  logic [3:0] addr_w;
  logic [4:0] bin_w, gray_w, remote_w, level_w;
  logic       inc_r, ok_r, blocked_r, almost_r;
  logic [3:0] addr_r;
  logic [4:0] bin_r, gray_r, remote_r, level_r;

  int n_checks = 0;
  int n_fail   = 0;

  gray_ptr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .MODE(0), .ALMOST_THRESH(2)) dut_w (
    .clk(clk), .rst(rst), .inc(inc_w), .ok(ok_w), .addr(addr_w), .bin(bin_w),
    .gray(gray_w), .remote_gray(remote_w), .blocked(blocked_w), .almost(almost_w),
    .level(level_w)
  );

  gray_ptr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .MODE(1), .ALMOST_THRESH(2)) dut_r (
    .clk(clk), .rst(rst), .inc(inc_r), .ok(ok_r), .addr(addr_r), .bin(bin_r),
    .gray(gray_r), .remote_gray(remote_r), .blocked(blocked_r), .almost(almost_r),
    .level(level_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         lvl, avail, accepts, wraps;
  logic       a;
  logic [4:0] exp_bin, prev_bin, prev_gray;
  logic [4:0] gh[$];

  initial begin
    rst = 1'b1; inc_w = 1'b0; inc_r = 1'b0; remote_w = '0; remote_r = '0;
    #1;
    // Reset values
    check_eq("rst_w_bin", bin_w, 0);
    check_eq("rst_w_gray", gray_w, 0);
    check_eq("rst_w_blocked", blocked_w, 0);
    check_eq("rst_w_level", level_w, 0);
    check_eq("rst_w_almost", almost_w, 0);
    check_eq("rst_r_blocked", blocked_r, 1);
    check_eq("rst_r_almost", almost_r, 1);
    step();
    rst = 1'b0;
    step();
    step();

    // Write side fill against a stationary remote pointer
    lvl = 0;
    for (int c = 0; c < 20; c++) begin
      inc_w = 1'b1;
      #1;
      check_eq("fill_ok", ok_w, (lvl < 16) ? 1 : 0);
      a = (lvl < 16);
      step();
      if (a) lvl++;
      check_eq("fill_level", level_w, lvl);
      check_eq("fill_blocked", blocked_w, (lvl == 16) ? 1 : 0);
      check_eq("fill_almost", almost_w, (lvl >= 14) ? 1 : 0);
    end
    inc_w = 1'b0;
    check_eq("fill_bin", bin_w, 16);
    check_eq("fill_gray", gray_w, 5'b11000);
    check_eq("fill_addr", addr_w, 0);

    // Read side drain: remote write pointer at 5
    remote_r = 5'b00111;
    step();
    step();
    check_eq("drain_sync_level", level_r, 0);
    check_eq("drain_sync_blocked", blocked_r, 1);
    step();
    check_eq("drain_level5", level_r, 5);
    check_eq("drain_blocked5", blocked_r, 0);
    check_eq("drain_almost5", almost_r, 0);
    avail = 5;
    for (int c = 0; c < 7; c++) begin
      inc_r = 1'b1;
      #1;
      check_eq("drain_ok", ok_r, (avail > 0) ? 1 : 0);
      a = (avail > 0);
      step();
      if (a) avail--;
      check_eq("drain_level", level_r, avail);
      check_eq("drain_blocked", blocked_r, (avail == 0) ? 1 : 0);
      check_eq("drain_almost", almost_r, (avail <= 2) ? 1 : 0);
    end
    inc_r = 1'b0;
    check_eq("drain_bin", bin_r, 5);

    // Wrap: remote follows local gray four cycles late
    gh.delete();
    for (int i = 0; i < 4; i++) gh.push_back(5'b11000);
    accepts = 0; wraps = 0;
    exp_bin = 5'd16; prev_bin = 5'd16; prev_gray = 5'b11000;
    inc_w = 1'b1;
    for (int k = 0; k < 400 && accepts < 70; k++) begin
      gh.push_back(gray_w);
      remote_w = gh.pop_front();
      #1;
      check_eq("wrap_ok", ok_w, !blocked_w);
      a = ok_w;
      step();
      if (a) accepts++;
      exp_bin = exp_bin + 5'(a);
      check_eq("wrap_bin", bin_w, exp_bin);
      check_eq("wrap_gray", gray_w, exp_bin ^ (exp_bin >> 1));
      if (gray_w != prev_gray) check_eq("wrap_gray_1bit", $countones(gray_w ^ prev_gray), 1);
      if (prev_bin == 5'd31 && bin_w == 5'd0) begin
        wraps++;
        check_eq("wrap_gray_prev", prev_gray, 5'b10000);
        check_eq("wrap_gray_zero", gray_w, 0);
      end
      check_eq("wrap_level_le_depth", (level_w <= 5'd16) ? 1 : 0, 1);
      prev_bin = bin_w;
      prev_gray = gray_w;
    end
    inc_w = 1'b0;
    check_eq("wrap_accepts", accepts, 70);
    check_eq("wrap_count", wraps, 2);

    // Full with simultaneous release: bin=22, remote bin=6 (gray 00101)
    remote_w = 5'b00101;
    for (int i = 0; i < 4; i++) step();
    check_eq("full_level", level_w, 16);
    check_eq("full_blocked", blocked_w, 1);
    check_eq("full_bin", bin_w, 22);
    remote_w = 5'b00100;
    inc_w = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq("release_ok", ok_w, (c == 3) ? 1 : 0);
      step();
    end
    inc_w = 1'b0;
    check_eq("release_level", level_w, 16);
    check_eq("release_blocked", blocked_w, 1);
    check_eq("release_bin", bin_w, 23);

    // Mid-operation asynchronous reset at bin=9
    rst = 1'b1;
    #1;
    rst = 1'b0;
    remote_w = '0;
    step();
    inc_w = 1'b1;
    for (int i = 0; i < 9; i++) step();
    inc_w = 1'b0;
    check_eq("pre_rst_bin", bin_w, 9);
    check_eq("pre_rst_level", level_w, 9);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_bin", bin_w, 0);
    check_eq("async_rst_gray", gray_w, 0);
    check_eq("async_rst_level", level_w, 0);
    check_eq("async_rst_blocked", blocked_w, 0);
    check_eq("async_rst_r_blocked", blocked_r, 1);
    rst = 1'b0;
    inc_w = 1'b1;
    #1;
    check_eq("post_rst_ok", ok_w, 1);
    step();
    inc_w = 1'b0;
    check_eq("post_rst_bin", bin_w, 1);
    check_eq("post_rst_gray", gray_w, 5'b00001);
    check_eq("post_rst_level", level_w, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gray_ptr_ctrl.md
Name: gray_ptr_ctrl

Overview:
Parametrised pointer controller for one side of a dual-clock FIFO.
- Runs entirely in its own clock domain.
- Keeps a binary and a registered Gray-coded pointer, one bit wider than the address.
- Synchronises the opposite side's Gray pointer, converts it to binary and produces a registered full or empty flag, an almost flag and an occupancy level.
- MODE selects write side (full) or read side (empty). Two instances form a complete async FIFO pointer path.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH; pointer width P = ADDR_WIDTH+1; ADDR_WIDTH >= 1
SYNC_STAGES, 2, flops in remote-pointer synchroniser chain; >= 2
MODE, 0, 0 = write side (full/almost_full), 1 = read side (empty/almost_empty)
ALMOST_THRESH, 2, margin for almost flag; 0..DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
inc  in  1  request to advance pointer by one
ok  out  1  request accepted this cycle = inc & ~blocked (combinational)
addr  out  ADDR_WIDTH  RAM address = bin[ADDR_WIDTH-1:0]
bin  out  P  local binary pointer (registered)
gray  out  P  local Gray pointer (registered, sent to other domain)
remote_gray  in  P  opposite side's Gray pointer (asynchronous to clk)
blocked  out  1  MODE0: full; MODE1: empty (registered)
almost  out  1  MODE0: almost_full; MODE1: almost_empty (registered)
level  out  P  MODE0: entries used; MODE1: entries available to read (registered)

Behaviour:
- Reset (async assert, released on clk):
  - bin, gray, all sync flops and level = 0.
  - MODE0: blocked = 0, almost = (ALMOST_THRESH >= DEPTH).
  - MODE1: blocked = 1, almost = 1.
- Accept: acc = inc & ~blocked. An inc while blocked is ignored, with no pointer change.
- Next pointer: nbin = bin + acc, mod 2**P.
  - Each clk: bin <= nbin; gray <= nbin ^ (nbin >> 1).
  - gray comes directly from a flop, so it is glitch-free and changes at most one bit per cycle.
- Synchroniser: remote_gray passes through SYNC_STAGES flops. rbin = Gray-to-binary of the last stage; bit i = XOR of sync[P-1:i].
- Arithmetic is modulo 2**P in P bits:
  - MODE0: nlevel = nbin - rbin.
  - MODE1: nlevel = rbin - nbin.
- Registered each clk: level <= nlevel.
  - MODE0: blocked <= (nlevel == DEPTH); almost <= (nlevel >= DEPTH - ALMOST_THRESH).
  - MODE1: blocked <= (nlevel == 0); almost <= (nlevel <= ALMOST_THRESH).
- Latency:
  - A local accept is reflected in bin, gray, level and blocked on the next edge. Full/empty therefore asserts in the same cycle the last slot is consumed, with no overrun.
  - A remote pointer change appears in level and blocked SYNC_STAGES+1 local cycles after it is stable at remote_gray.
  - Flags are pessimistic: they deassert late, never assert late.
- Wrap: the pointer wraps 2**P-1 -> 0. Gray wraps from 1 followed by ADDR_WIDTH zeros to all zeros, a single-bit change. Level stays correct across the wrap.
- Simultaneous accept and remote advance in one cycle: both are included in nlevel. The count never exceeds DEPTH and never goes below 0.
- Reset mid-operation: all state returns to reset values immediately. Both FIFO sides must be reset together; this is a system-level requirement, not checked here.

Test Plan:
1. Reset, ADDR_WIDTH=4: MODE0 gives bin=0, gray=0, blocked=0, level=0, almost=0; MODE1 gives blocked=1, almost=1.
2. MODE0 fill: remote_gray=0, inc=1 for 20 cycles.
   - ok=1 for the first 16 cycles, then 0.
   - After the 16th accept: bin=16, gray=5'b11000, level=16, blocked=1.
   - almost=1 once level reaches 14.
3. MODE1 drain: remote_gray=5'b00111 (bin 5), inc=0.
   - After 3 cycles (SYNC_STAGES=2): level=5, blocked=0.
   - inc=1 for 7 cycles: ok=1 for 5 cycles, then blocked=1 and level=0.
4. Wrap: MODE0, remote_gray tracks the local gray delayed by 4 cycles, 70 accepts.
   - bin passes 31->0 with gray 5'b10000->5'b00000.
   - level never exceeds 16; bench checks every gray transition differs in exactly 1 bit.
5. Full with simultaneous release: MODE0 at level=16; remote advances 1 while inc stays 1.
   - ok stays 0 for 3 cycles, then ok=1 for exactly one accept.
   - level returns to 16 and blocked=1.
6. Mid-operation reset: at bin=9, pulse rst between clock edges.
   - Outputs go to reset values asynchronously, before the next edge.
   - The first accept after release gives bin=1, gray=5'b00001.
